// File: rtl/pio_event_master.sv
`default_nettype none
// ============================================================================
// Module      : pio_event_master
// Description : Avalon-MM initiator that services an edge-capture PIO on irq
//               and queues {edges, level} events. Optional macro
//               PIO_EVENT_TIMESTAMP_EN prepends a 16-bit cycle timestamp.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_event_master #(
    parameter int                DATA_W        = 10,
    parameter int                READ_LATENCY  = 1,
    parameter int                FIFO_DEPTH    = 8,
    parameter logic [DATA_W-1:0] IRQ_MASK_INIT = '1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  irq,
    output logic [1:0]            m_address,
    output logic                  m_chipselect,
    output logic                  m_write_n,
    output logic [31:0]           m_writedata,
    input  logic [31:0]           m_readdata,
    output logic                  evt_valid,
    input  logic                  evt_ready,
`ifdef PIO_EVENT_TIMESTAMP_EN
    output logic [2*DATA_W+15:0]  evt_data,
`else
    output logic [2*DATA_W-1:0]   evt_data,
`endif
    output logic                  evt_overflow,
    input  logic                  clr_overflow
);

`ifdef PIO_EVENT_TIMESTAMP_EN
    localparam int c_evt_w = 2*DATA_W + 16;
`else
    localparam int c_evt_w = 2*DATA_W;
`endif
    localparam int             c_aw      = $clog2(FIFO_DEPTH);
    localparam int             c_cw      = $clog2(READ_LATENCY + 2);
    localparam logic [c_cw-1:0] c_rd_last = c_cw'(READ_LATENCY);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_RD_EDGE = 3'd2,
        S_CLR     = 3'd3,
        S_RD_DATA = 3'd4,
        S_PUSH    = 3'd5
    } state_t;

    state_t              r_state;
    logic [c_cw-1:0]     r_cnt;
    logic [DATA_W-1:0]   r_edge;
    logic [DATA_W-1:0]   r_level;
    logic                w_unused_rd;

    assign w_unused_rd = ^m_readdata[31:DATA_W];

`ifdef PIO_EVENT_TIMESTAMP_EN
    logic [15:0] r_ts;
    logic [15:0] r_ts_lat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_ts <= '0;
        else          r_ts <= r_ts + 16'd1;
    end
`endif

    // Bus outputs are loaded on the edge entering a state, so they are
    // valid for the whole time the FSM sits in that state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_INIT;
            r_cnt        <= '0;
            r_edge       <= '0;
            r_level      <= '0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= 2'd0;
            m_writedata  <= 32'd0;
`ifdef PIO_EVENT_TIMESTAMP_EN
            r_ts_lat     <= '0;
`endif
        end else begin
            case (r_state)
                S_INIT: begin
                    if (!m_chipselect) begin
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_address    <= 2'd2;
                        m_writedata  <= 32'(IRQ_MASK_INIT);
                    end else begin
                        m_chipselect <= 1'b0;
                        m_write_n    <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (irq && enable) begin
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b1;
                        m_address    <= 2'd3;
                        r_cnt        <= '0;
                        r_state      <= S_RD_EDGE;
                    end
                end
                S_RD_EDGE: begin
                    if (r_cnt == c_rd_last) begin
                        r_edge <= m_readdata[DATA_W-1:0];
`ifdef PIO_EVENT_TIMESTAMP_EN
                        r_ts_lat <= r_ts;
`endif
                        if (m_readdata[DATA_W-1:0] == '0) begin
                            m_chipselect <= 1'b0;
                            r_state      <= S_IDLE;
                        end else begin
                            m_write_n   <= 1'b0;
                            m_writedata <= 32'hFFFF_FFFF;
                            r_state     <= S_CLR;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CLR: begin
                    m_write_n <= 1'b1;
                    m_address <= 2'd0;
                    r_cnt     <= '0;
                    r_state   <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (r_cnt == c_rd_last) begin
                        r_level      <= m_readdata[DATA_W-1:0];
                        m_chipselect <= 1'b0;
                        r_state      <= S_PUSH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PUSH:  r_state <= S_IDLE;
                default: r_state <= S_INIT;
            endcase
        end
    end

    logic [c_evt_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_aw:0]      r_wr_ptr;
    logic [c_aw:0]      r_rd_ptr;
    logic               w_full;
    logic               w_pop;
    logic               w_push_req;
    logic               w_push;
    logic               w_drop;
    logic [c_evt_w-1:0] w_push_data;

`ifdef PIO_EVENT_TIMESTAMP_EN
    assign w_push_data = {r_ts_lat, r_edge, r_level};
`else
    assign w_push_data = {r_edge, r_level};
`endif

    assign w_full     = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                        (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign evt_valid  = (r_wr_ptr != r_rd_ptr);
    assign evt_data   = r_mem[r_rd_ptr[c_aw-1:0]];
    assign w_pop      = evt_valid && evt_ready;
    assign w_push_req = (r_state == S_PUSH);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= w_push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_drop)            evt_overflow <= 1'b1;
            else if (clr_overflow) evt_overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pio_event_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_event_master
// Description : Scoreboard bench for pio_event_master with an edge-capture
//               PIO slave model and randomized event stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_event_master;
    localparam int DW    = 10;
    localparam int RL    = 1;
    localparam int DEPTH = 8;
`ifdef PIO_EVENT_TIMESTAMP_EN
    localparam int EW = 2*DW + 16;
`else
    localparam int EW = 2*DW;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, enable, irq, clr_overflow;
    logic [1:0]    m_address;
    logic          m_chipselect, m_write_n;
    logic [31:0]   m_writedata, m_readdata;
    logic          evt_valid, evt_ready, evt_overflow;
    logic [EW-1:0] evt_data;

    pio_event_master #(.DATA_W(DW), .READ_LATENCY(RL), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .irq(irq),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .m_readdata(m_readdata),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
        .evt_overflow(evt_overflow), .clr_overflow(clr_overflow)
    );

    // Edge-capture PIO slave: writes to the capture register clear set bits.
    logic [DW-1:0] slv_edge = '0;
    logic [DW-1:0] slv_mask = '0;
    logic [DW-1:0] inj_edge = '0;
    logic [31:0]   slv_data = '0;
    logic [31:0]   rd_pipe  = '0;
    logic          irq_force = 1'b0;

    always @(posedge clk) begin
        logic [31:0] j;
        j = $urandom;
        if (m_chipselect && !m_write_n && m_address == 2'd2) slv_mask <= m_writedata[DW-1:0];
        if (m_chipselect && !m_write_n && m_address == 2'd3)
            slv_edge <= (slv_edge & ~m_writedata[DW-1:0]) | inj_edge;
        else
            slv_edge <= slv_edge | inj_edge;
        if (m_chipselect && m_write_n) begin
            case (m_address)
                2'd0:    rd_pipe <= slv_data;
                2'd2:    rd_pipe <= {j[31:DW], slv_mask};
                2'd3:    rd_pipe <= {j[31:DW], slv_edge};
                default: rd_pipe <= j;
            endcase
        end else begin
            rd_pipe <= j;
        end
    end
    assign m_readdata = rd_pipe;
    assign irq        = (|(slv_edge & slv_mask)) | irq_force;

    logic rand_mode = 1'b0, rnd_ready = 1'b0, fix_ready = 1'b0;
    assign evt_ready = rand_mode ? rnd_ready : fix_ready;
    initial forever begin
        @(posedge clk); #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [34:0]     bus_q[$];
    logic [2*DW-1:0] evt_q[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    function automatic void note_fail(string name, logic [63:0] act);
        n_checks++;
        $display("FAIL %s: got 0x%0h expected none", name, act);
    endfunction

    function automatic void bus_seen(logic [34:0] t);
        if (bus_q.size() == 0) note_fail("bus_unexpected", 64'(t));
        else chk("bus_txn", 64'(t), 64'(bus_q.pop_front()));
    endfunction

    // Bus monitor: a write is one strobed cycle, a read is RL+1 held cycles.
    int          run = 0;
    logic [1:0]  run_addr = '0;
    always @(negedge clk) begin
        if (!reset_n) begin
            run = 0;
        end else if (m_chipselect && !m_write_n) begin
            if (run != 0) begin note_fail("bus_read_short", 64'(run)); run = 0; end
            bus_seen({1'b1, m_address, m_writedata});
        end else if (m_chipselect) begin
            if (run != 0 && m_address != run_addr) begin
                note_fail("bus_read_addr_change", 64'(m_address)); run = 0;
            end
            run_addr = m_address;
            run++;
            if (run == RL + 1) begin bus_seen({1'b0, m_address, 32'h0}); run = 0; end
        end else begin
            if (run != 0) note_fail("bus_read_short", 64'(run));
            run = 0;
        end
    end

    always @(negedge clk) begin
        if (reset_n && evt_valid && evt_ready) begin
            if (evt_q.size() == 0) note_fail("evt_unexpected", 64'(evt_data));
            else chk("evt_data", 64'(evt_data[2*DW-1:0]), 64'(evt_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic inject(input logic [DW-1:0] e, input logic [31:0] d);
        slv_data = d;
        inj_edge = e;
        tick();
        inj_edge = '0;
    endtask

    // Reference: one serviced interrupt = read capture, clear it, read level.
    task automatic expect_seq(input logic [DW-1:0] e, input logic [31:0] d, input bit store);
        bus_q.push_back({1'b0, 2'd3, 32'h0});
        bus_q.push_back({1'b1, 2'd3, 32'hFFFF_FFFF});
        bus_q.push_back({1'b0, 2'd0, 32'h0});
        if (store) evt_q.push_back({e, d[DW-1:0]});
    endtask

    task automatic wait_bus_done(input int max);
        int n = 0;
        while (bus_q.size() != 0 && n < max) begin tick(); n++; end
        if (bus_q.size() != 0) note_fail("bus_timeout", 64'(bus_q.size()));
        repeat (4) tick();
    endtask

    task automatic wait_evt_empty(input int max);
        int n = 0;
        while (evt_q.size() != 0 && n < max) begin tick(); n++; end
        if (evt_q.size() != 0) note_fail("evt_timeout", 64'(evt_q.size()));
        tick();
    endtask

    task automatic issue_event(input logic [DW-1:0] e, input logic [31:0] d, input bit store);
        expect_seq(e, d, store);
        inject(e, d);
        wait_bus_done(100);
    endtask

    int wcnt;

    initial begin
        reset_n = 1'b0; enable = 1'b1; clr_overflow = 1'b0;
        #12;
        chk("rst_cs", 64'(m_chipselect), 64'd0);
        chk("rst_wn", 64'(m_write_n), 64'd1);
        chk("rst_addr", 64'(m_address), 64'd0);
        chk("rst_wdata", 64'(m_writedata), 64'd0);
        chk("rst_valid", 64'(evt_valid), 64'd0);
        chk("rst_ovf", 64'(evt_overflow), 64'd0);
        bus_q.push_back({1'b1, 2'd2, 32'h0000_03FF});
        tick();
        reset_n = 1'b1;
        wait_bus_done(50);
        repeat (10) tick();

        // Basic event
        issue_event(10'h005, 32'h105, 1'b1);
        chk("evt_valid_after_push", 64'(evt_valid), 64'd1);
        chk("evt_head", 64'(evt_data[2*DW-1:0]), 64'({10'h005, 10'h105}));
        fix_ready = 1'b1;
        wait_evt_empty(50);

        // Spurious interrupt: only the capture read happens
        bus_q.push_back({1'b0, 2'd3, 32'h0});
        irq_force = 1'b1;
        wcnt = 0;
        while (!m_chipselect && wcnt < 20) begin tick(); wcnt++; end
        irq_force = 1'b0;
        wait_bus_done(50);
        chk("spurious_no_event", 64'(evt_valid), 64'd0);

        // Disabled: pending irq is ignored until enable returns
        enable = 1'b0;
        inject(10'h3C0, 32'hABCD_E2AA);
        repeat (10) tick();
        chk("disabled_idle", 64'(m_chipselect), 64'd0);
        expect_seq(10'h3C0, 32'hABCD_E2AA, 1'b1);
        enable = 1'b1;
        wait_bus_done(100);
        wait_evt_empty(50);

        // Overflow: 9 interrupts into an 8-deep FIFO with no consumer
        fix_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            issue_event(DW'($urandom_range(1, 1023)), $urandom, i < DEPTH);
            if (i == DEPTH - 1) chk("ovf_at_full", 64'(evt_overflow), 64'd0);
        end
        chk("ovf_set", 64'(evt_overflow), 64'd1);
        chk("valid_when_full", 64'(evt_valid), 64'd1);
        fix_ready = 1'b1;
        wait_evt_empty(100);
        chk("drained_valid", 64'(evt_valid), 64'd0);
        chk("ovf_sticky", 64'(evt_overflow), 64'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovf_cleared", 64'(evt_overflow), 64'd0);

        // Full FIFO with the consumer popping in the PUSH cycle
        fix_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) issue_event(DW'($urandom_range(1, 1023)), $urandom, 1'b1);
        expect_seq(10'h2A5, 32'h0000_0133, 1'b1);
        inject(10'h2A5, 32'h0000_0133);
        wcnt = 0;
        while (!(m_chipselect && m_write_n && m_address == 2'd0) && wcnt < 50) begin tick(); wcnt++; end
        while (m_chipselect && wcnt < 50) begin tick(); wcnt++; end
        if (wcnt >= 50) note_fail("push_wait_timeout", 64'(wcnt));
        fix_ready = 1'b1;
        wait_bus_done(50);
        chk("ovf_full_with_pop", 64'(evt_overflow), 64'd0);
        wait_evt_empty(100);

        // Random events with a random consumer
        rand_mode = 1'b1;
        for (int i = 0; i < 25; i++) begin
            wcnt = 0;
            while (evt_q.size() >= DEPTH - 1 && wcnt < 200) begin tick(); wcnt++; end
            if (wcnt >= 200) note_fail("rand_drain_timeout", 64'(evt_q.size()));
            issue_event(DW'($urandom_range(1, 1023)), $urandom, 1'b1);
        end
        rand_mode = 1'b0;
        fix_ready = 1'b1;
        wait_evt_empty(200);
        chk("rand_no_ovf", 64'(evt_overflow), 64'd0);

        // Reset asserted during the clear write
        fix_ready = 1'b0;
        issue_event(10'h011, 32'h0000_0022, 1'b1);
        expect_seq(10'h0F0, 32'h0000_030F, 1'b1);
        inject(10'h0F0, 32'h0000_030F);
        wcnt = 0;
        while (!(m_chipselect && !m_write_n && m_address == 2'd3) && wcnt < 50) begin tick(); wcnt++; end
        if (wcnt >= 50) note_fail("clr_wait_timeout", 64'(wcnt));
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_cs", 64'(m_chipselect), 64'd0);
        chk("rst_mid_valid", 64'(evt_valid), 64'd0);
        bus_q.delete();
        evt_q.delete();
        bus_q.push_back({1'b1, 2'd2, 32'h0000_03FF});
        expect_seq(10'h0F0, 32'h0000_030F, 1'b1);
        repeat (3) tick();
        reset_n = 1'b1;
        wait_bus_done(100);
        fix_ready = 1'b1;
        wait_evt_empty(50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
